// File: rtl/alu_ctrl_pkg.sv
// Shared types and slice-control decode for the bit-serial ALU sequencer.
// Optional overflow output is enabled with ALU_SERIAL_OVF_EN.
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_NOR  = 3'b100,
      OP_NAND = 3'b101,
      OP_RSV6 = 3'b110,
      OP_RSV7 = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_ADD = 2'b10;

   // Per-bit slice controls held constant for the whole RUN phase.
   typedef struct packed {
      logic       a_inv;
      logic       b_inv;
      logic [1:0] sel;
      logic       arith;
   } slice_ctrl_t;

   function automatic logic op_is_legal(input op_t op);
      return (op != OP_RSV6) && (op != OP_RSV7);
   endfunction

   // Carry loaded into the carry register at accept (SUB adds the +1 of ~B+1).
   function automatic logic op_carry_init(input op_t op);
      return (op == OP_SUB);
   endfunction

   function automatic slice_ctrl_t decode_op(input op_t op);
      slice_ctrl_t c;
      c = '0;
      case (op)
         OP_AND:  c.sel = SEL_AND;
         OP_OR:   c.sel = SEL_OR;
         OP_ADD:  begin c.sel = SEL_ADD; c.arith = 1'b1; end
         OP_SUB:  begin c.sel = SEL_ADD; c.arith = 1'b1; c.b_inv = 1'b1; end
         OP_NOR:  begin c.sel = SEL_AND; c.a_inv = 1'b1; c.b_inv = 1'b1; end
         OP_NAND: begin c.sel = SEL_OR;  c.a_inv = 1'b1; c.b_inv = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu1b.sv
// One-bit ALU slice: optional operand inversion, AND / OR / full-add select.
// Carry out is the full-adder carry of the (possibly inverted) operands.
module alu1b
   import alu_ctrl_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       a_inv,
   input  logic       b_inv,
   input  logic       c_in,
   input  logic [1:0] sel,
   output logic       x,
   output logic       c_out
);

   logic aa;
   logic bb;

   assign aa = a ^ a_inv;
   assign bb = b ^ b_inv;

   // Result select; encoding 11 is unused and yields 0.
   always_comb begin
      x = 1'b0;
      case (sel)
         SEL_AND: x = aa & bb;
         SEL_OR:  x = aa | bb;
         SEL_ADD: x = aa ^ bb ^ c_in;
         default: x = 1'b0;
      endcase
   end

   assign c_out = (aa & bb) | (aa & c_in) | (bb & c_in);

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a single alu1b slice over WIDTH bits, LSB first.
// Start/done handshake; reserved opcodes finish immediately with err.
// Define ALU_SERIAL_OVF_EN to add the signed-overflow output.
module alu_serial_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
`ifdef ALU_SERIAL_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t            state;
   op_t               op_q;
   op_t               op_req;
   slice_ctrl_t       run_ctrl;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   logic [WIDTH-1:0]  res_sr;
   logic [CNT_W-1:0]  cnt;
   logic              carry_q;
   logic              err_q;
`ifdef ALU_SERIAL_OVF_EN
   logic              msb_cin_q;
`endif

   logic              s_a;
   logic              s_b;
   logic              s_a_inv;
   logic              s_b_inv;
   logic              s_cin;
   logic [1:0]        s_sel;
   logic              s_x;
   logic              s_cout;

   assign op_req   = op_t'(op);
   assign run_ctrl = decode_op(op_q);

   // Slice is only fed during RUN; all inputs are held at 0 otherwise.
   always_comb begin
      s_a     = 1'b0;
      s_b     = 1'b0;
      s_a_inv = 1'b0;
      s_b_inv = 1'b0;
      s_cin   = 1'b0;
      s_sel   = 2'b00;
      if (state == RUN) begin
         s_a     = a_sr[0];
         s_b     = b_sr[0];
         s_a_inv = run_ctrl.a_inv;
         s_b_inv = run_ctrl.b_inv;
         s_cin   = carry_q;
         s_sel   = run_ctrl.sel;
      end
   end

   alu1b u_slice (
      .a     (s_a),
      .b     (s_b),
      .a_inv (s_a_inv),
      .b_inv (s_b_inv),
      .c_in  (s_cin),
      .sel   (s_sel),
      .x     (s_x),
      .c_out (s_cout)
   );

   // Sequencer FSM with operand/result shift registers and the threaded carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= OP_AND;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         cnt     <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         msb_cin_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (op_is_legal(op_req)) begin
                     a_sr    <= a_in;
                     b_sr    <= b_in;
                     op_q    <= op_req;
                     cnt     <= '0;
                     carry_q <= op_carry_init(op_req);
                     err_q   <= 1'b0;
                     state   <= RUN;
                  end else begin
                     err_q   <= 1'b1;
                     state   <= FIN;
                  end
               end
            end
            RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               res_sr  <= {s_x, res_sr[WIDTH-1:1]};
               carry_q <= s_cout;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
`ifdef ALU_SERIAL_OVF_EN
                  msb_cin_q <= carry_q;
`endif
                  state <= FIN;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Registered handshake outputs; busy lags the RUN state by one cycle so it
   // hands over directly to the done pulse issued as FIN is left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         overflow  <= 1'b0;
`endif
      end else begin
         busy <= (state == RUN);
         done <= (state == FIN);
         err  <= (state == FIN) && err_q;
         if ((state == FIN) && !err_q) begin
            result    <= res_sr;
            carry_out <= run_ctrl.arith & carry_q;
`ifdef ALU_SERIAL_OVF_EN
            overflow  <= run_ctrl.arith & (msb_cin_q ^ carry_q);
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl at WIDTH=8.
// Overflow checks are compiled in when ALU_SERIAL_OVF_EN is defined.
module tb_alu_serial_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] result;
   logic         carry_out;
`ifdef ALU_SERIAL_OVF_EN
   logic         overflow;
`endif

   int tests = 0;
   int fails = 0;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .result    (result),
      .carry_out (carry_out)
`ifdef ALU_SERIAL_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         co;
      logic         ovf;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issue one op and wait (bounded) for done; lat = cycles from accept edge.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_bad, output logic err_seen);
      @(negedge clk);
      op = o; a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_bad = 0;
      if (busy !== 1'b0) busy_bad++;
      lat = -1;
      err_seen = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k;
            err_seen = err;
            if (busy !== 1'b0) busy_bad++;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
      end
   endtask

   int   lat;
   int   bb;
   logic e;
   int   k1;
   int   k2;
   int   ndone;

   initial begin
      vecs[0]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
      vecs[1]  = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
      vecs[2]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[3]  = '{3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
      vecs[4]  = '{3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[5]  = '{3'b011, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
      vecs[6]  = '{3'b100, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0};
      vecs[7]  = '{3'b101, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0};
      vecs[8]  = '{3'b011, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[10] = '{3'b011, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset busy", {31'd0, busy}, 0);
      check("reset done", {31'd0, done}, 0);
      check("reset err", {31'd0, err}, 0);
      check("reset result", {24'd0, result}, 0);
      check("reset carry_out", {31'd0, carry_out}, 0);
`ifdef ALU_SERIAL_OVF_EN
      check("reset overflow", {31'd0, overflow}, 0);
`endif

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bb, e);
         check($sformatf("v%0d latency", i), lat, W + 1);
         check($sformatf("v%0d busy", i), bb, 0);
         check($sformatf("v%0d err", i), {31'd0, e}, 0);
         check($sformatf("v%0d result", i), {24'd0, result}, {24'd0, vecs[i].res});
         check($sformatf("v%0d carry_out", i), {31'd0, carry_out}, {31'd0, vecs[i].co});
`ifdef ALU_SERIAL_OVF_EN
         check($sformatf("v%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
`endif
      end

      // Reserved op leaves the previous result (0x7F, carry 1) untouched.
      run_op(3'b111, 8'h11, 8'h22, lat, bb, e);
      check("rsv7 latency", lat, 1);
      check("rsv7 err", {31'd0, e}, 1);
      check("rsv7 busy", bb, 0);
      check("rsv7 result held", {24'd0, result}, 32'h7F);
      check("rsv7 carry held", {31'd0, carry_out}, 1);

      // Start while busy is ignored: exactly one done with the AND result.
      @(negedge clk);
      op = 3'b000; a_in = 8'hF0; b_in = 8'h3C; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; k1 = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (k == 2) begin
            start = 1'b1; op = 3'b010; a_in = 8'h01; b_in = 8'h01;
         end
         if (k == 3) start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (k1 < 0) k1 = k;
         end
      end
      check("busy-start done count", ndone, 1);
      check("busy-start latency", k1, W + 1);
      check("busy-start result", {24'd0, result}, 32'h30);

      // Back-to-back issue with start held high.
      @(negedge clk);
      op = 3'b011; a_in = 8'h07; b_in = 8'h05; start = 1'b1;
      @(posedge clk); #1;
      k1 = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin k1 = k; break; end
      end
      check("b2b first latency", k1, W + 1);
      k2 = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) start = 1'b0;
         if (done === 1'b1) begin k2 = k; break; end
      end
      check("b2b interval", k2, W + 2);
      check("b2b result", {24'd0, result}, 32'h02);
      check("b2b carry_out", {31'd0, carry_out}, 1);

      // Reset in the middle of an op clears everything and suppresses done.
      @(negedge clk);
      op = 3'b010; a_in = 8'hFF; b_in = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst busy", {31'd0, busy}, 0);
      check("midrst done", {31'd0, done}, 0);
      check("midrst result", {24'd0, result}, 0);
      check("midrst carry_out", {31'd0, carry_out}, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      check("midrst no done", ndone, 0);

      run_op(3'b110, 8'hAA, 8'h55, lat, bb, e);
      check("rsv6 latency", lat, 1);
      check("rsv6 err", {31'd0, e}, 1);
      check("rsv6 result", {24'd0, result}, 0);
      check("rsv6 carry_out", {31'd0, carry_out}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer that drives one `alu1b` slice over a WIDTH-bit operand pair, one bit per clock, LSB first. It accepts an operation plus operands through a start/done handshake. It sets the slice's invert, carry-in and select controls, threads the carry through a register between bits, and assembles the WIDTH-bit result. It sits between the lab's control logic and the 1-bit ALU, so a wide ALU operation is obtained without replicating the slice.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2 to 32.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: operation code, see Operation.
- `a_in` input WIDTH: operand A, latched at accepted start.
- `b_in` input WIDTH: operand B, latched at accepted start.
- `busy` output 1: high from the cycle after accept until done.
- `done` output 1: one-cycle pulse, result valid.
- `err` output 1: one-cycle pulse with done for a reserved op.
- `result` output WIDTH: assembled result; holds until the next accepted start.
- `carry_out` output 1: final slice carry (ADD/SUB); 0 for logic ops.

## Operation
- Opcodes and the slice controls they set (a_inv, b_inv, s1s0, initial carry):
  - 000 AND: 0, 0, 00, 0.
  - 001 OR: 0, 0, 01, 0.
  - 010 ADD: 0, 0, 10, 0.
  - 011 SUB, computed as A + ~B + 1: 0, 1, 10, 1.
  - 100 NOR, computed as ~A & ~B: 1, 1, 00, 0.
  - 101 NAND, computed as ~A | ~B: 1, 1, 01, 0.
  - 110 and 111: reserved.
- FSM states are IDLE, RUN and FIN. Reset state is IDLE.
- IDLE behaviour:
  - On `start`=1 with a legal op: latch operands into A/B shift registers, latch op, clear the bit counter, load the carry register with the initial carry, go to RUN.
  - On `start`=1 with a reserved op: go to FIN with an error flag set; operands are not latched.
- RUN behaviour, each cycle:
  - Slice a = A_sr[0], b = B_sr[0], c_in = carry register.
  - Shift A_sr and B_sr right.
  - Shift slice x into the MSB of the result shift register.
  - Carry register <= slice c_out.
  - Counter++. When the counter reaches WIDTH-1, go to FIN.
- FIN behaviour: for one cycle, done=1, err = error flag, and `result`/`carry_out` are updated. Then go to IDLE.
- For a reserved op, `result` and `carry_out` are unchanged.
- `start` asserted outside IDLE is ignored; it is not queued.
- In IDLE and FIN, slice inputs are driven to 0.
- Carry convention: for SUB, carry_out=1 means no borrow.
- A reset asserted at any point aborts the operation immediately. Every output and register goes to 0: `busy`, `done`, `err`, `result` and `carry_out` all reset to 0.

## Timing
- Accept edge is T0. `busy` is high from T0+1 through T0+WIDTH.
- `done` is high in cycle T0+WIDTH+1, so latency is WIDTH+1 cycles. Back-to-back issue is possible: `start` held high is accepted again at the edge that leaves FIN toward IDLE plus one, giving a throughput of one op per WIDTH+2 cycles.
- Reserved op: `done`/`err` are high at T0+1.
- Critical path: shift register bit0 -> slice -> carry/result registers, all within one cycle.

## Configuration
- `ALU_SERIAL_OVF_EN` defined:
  - Adds output `overflow` (1 bit, reset 0).
  - The carry into the MSB is registered during the last RUN cycle.
  - `overflow` = carry_in_msb XOR carry_out for ADD/SUB, and 0 for other ops; valid with `done`, held until the next accepted start.
- `ALU_SERIAL_OVF_EN` undefined: no `overflow` port and no extra logic.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the `op_t` enum (3 bits);
  - the `state_t` enum (IDLE, RUN, FIN);
  - localparams for the s1s0 encodings (AND 00, OR 01, ADD 10).
- One sub-module: `alu1b`, instantiated once as the datapath slice. All sequencing logic is local to `alu_serial_ctrl`.

## Test plan
- AND: op=000, A=0xF0, B=0x3C -> done at T0+9, result=0x30, carry_out=0.
- ADD wrap-around: op=010, A=0xFF, B=0x01 -> result=0x00, carry_out=1. With OVF_EN, the same op with A=0x7F, B=0x01 -> result=0x80, overflow=1.
- SUB with borrow: op=011, A=0x05, B=0x07 -> result=0xFE, carry_out=0. Repeat with A=0x07, B=0x05 -> result=0x02, carry_out=1.
- NOR/NAND: A=0xA5, B=0x0F. NOR -> 0x50; NAND -> 0xFA.
- Start while busy: second start at T0+3 with different operands is ignored; only one done pulse, with the first op's result.
- Reset mid-op at T0+4 -> all outputs 0 immediately and no done pulse. A subsequent reserved op=110 -> done=err=1 at T0'+1, result still 0.
